// File: rtl/fb_pixel_fetch.sv
// Framebuffer prefetch engine: streams IMG_W*IMG_H bytes from a RAM_LAT-cycle
// synchronous RAM into a small FIFO and hands them to the VGA pixel stage.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   frame_start       one-cycle pulse, restarts fetch at address 0
//   pix_req           consumer pops one pixel this cycle
//   ram_addr, ram_rd  read address / read strobe to the framebuffer RAM
//   ram_q             read data, valid RAM_LAT cycles after ram_rd
//   pix_data          pixel handed to the VGA stage (latency 1 from pix_req)
//   pix_valid         pix_data holds a real fetched pixel this cycle
//   fetch_ready       FIFO primed, consumer may start popping
//   underrun          sticky: a pop found the FIFO empty
//   underrun_cnt      saturating underrun count, only with
//                     `define FB_FETCH_UNDERRUN_CNT_EN
module fb_pixel_fetch #(
   parameter int IMG_W      = 256,
   parameter int IMG_H      = 256,
   parameter int ADDR_W     = 16,
   parameter int RAM_LAT    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              pix_req,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   input  logic [7:0]        ram_q,
   output logic [7:0]        pix_data,
   output logic              pix_valid,
   output logic              fetch_ready,
   output logic              underrun
`ifdef FB_FETCH_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       underrun_cnt
`endif
);

   localparam int TOTAL = IMG_W * IMG_H;
   localparam int IW    = $clog2(TOTAL + 1);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = $clog2(FIFO_DEPTH + 1);
   localparam int LW    = $clog2(RAM_LAT + 1);

   typedef enum logic [1:0] {
      IDLE,
      PREFILL,
      STREAM,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      issued_q;
   logic [RAM_LAT-1:0] vld_q, vld_d;
   logic [7:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [LW-1:0]      inflight;
   logic               push, pop, empty_pop;
   logic               all_issued, all_issued_d;

   assign ram_addr    = ADDR_W'(issued_q);
   assign fetch_ready = (state_q == STREAM);
   assign all_issued  = (issued_q == IW'(TOTAL));
   // the oldest in-flight flag marks the read whose data is on ram_q now
   assign push        = vld_q[RAM_LAT-1];

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RAM_LAT; i++)
         inflight = inflight + LW'(vld_q[i]);
   end

   always_comb begin
      state_d   = state_q;
      ram_rd    = 1'b0;
      pop       = 1'b0;
      empty_pop = 1'b0;

      // reads still in flight already own a FIFO slot
      if ((state_q == PREFILL || state_q == STREAM) && !all_issued &&
          (int'(cnt_q) + int'(inflight) < FIFO_DEPTH))
         ram_rd = 1'b1;

      if (!frame_start && pix_req && state_q != IDLE) begin
         if (cnt_q != '0)
            pop = 1'b1;
         else
            empty_pop = 1'b1;
      end

      cnt_d        = cnt_q + CW'(push) - CW'(pop);
      vld_d        = (vld_q << 1) | RAM_LAT'(ram_rd);
      all_issued_d = ((issued_q + IW'(ram_rd)) == IW'(TOTAL));

      // transitions look at the post-edge FIFO and in-flight picture
      unique case (state_q)
         IDLE: ;
         PREFILL:
            if (cnt_d == CW'(FIFO_DEPTH) ||
                (all_issued_d && vld_d == '0))
               state_d = STREAM;
         STREAM:
            if (all_issued_d && vld_d == '0 && cnt_d == '0)
               state_d = DONE;
         DONE: ;
      endcase

      if (frame_start)
         state_d = PREFILL;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         issued_q  <= '0;
         vld_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
         underrun  <= 1'b0;
      end else if (frame_start) begin
         // dropping the flags discards every read still in flight
         issued_q  <= '0;
         vld_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         pix_valid <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         issued_q  <= issued_q + IW'(ram_rd);
         vld_q     <= vld_d;
         cnt_q     <= cnt_d;
         pix_valid <= pop;
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            pix_data <= mem[rd_ptr_q];
         end else if (empty_pop) begin
            pix_data <= 8'h00;
         end
         if (empty_pop)
            underrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset && !frame_start)
         mem[wr_ptr_q] <= ram_q;
   end

`ifdef FB_FETCH_UNDERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (reset || frame_start)
         underrun_cnt <= '0;
      else if (empty_pop && underrun_cnt != 16'hFFFF)
         underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Self-checking bench for fb_pixel_fetch: a default-size instance driven by
// a vector table and directed sequences, plus a 4x2 instance under a model.
module tb_fb_pixel_fetch;

   localparam int LAT     = 2;
   localparam int S_TOT   = 8;
   localparam int S_DEPTH = 4;
   localparam int M_IDLE  = 0;
   localparam int M_PRE   = 1;
   localparam int M_STR   = 2;
   localparam int M_DONE  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0] ram_xor;

   function automatic logic [7:0] ram_val(input logic [15:0] a);
      return a[7:0] ^ ram_xor;
   endfunction

   logic        fs_b, req_b, rd_b, pv_b, rdy_b, un_b;
   logic [15:0] addr_b;
   logic [7:0]  q_b, pd_b;
   logic        fs_s, req_s, rd_s, pv_s, rdy_s, un_s;
   logic [15:0] addr_s;
   logic [7:0]  q_s, pd_s;
`ifdef FB_FETCH_UNDERRUN_CNT_EN
   logic [15:0] cnt_b, cnt_s;
`endif

   fb_pixel_fetch u_big (
      .clk(clk), .reset(rst), .frame_start(fs_b), .pix_req(req_b),
      .ram_addr(addr_b), .ram_rd(rd_b), .ram_q(q_b),
      .pix_data(pd_b), .pix_valid(pv_b), .fetch_ready(rdy_b),
      .underrun(un_b)
`ifdef FB_FETCH_UNDERRUN_CNT_EN
      , .underrun_cnt(cnt_b)
`endif
   );

   fb_pixel_fetch #(.IMG_W(4), .IMG_H(2)) u_small (
      .clk(clk), .reset(rst), .frame_start(fs_s), .pix_req(req_s),
      .ram_addr(addr_s), .ram_rd(rd_s), .ram_q(q_s),
      .pix_data(pd_s), .pix_valid(pv_s), .fetch_ready(rdy_s),
      .underrun(un_s)
`ifdef FB_FETCH_UNDERRUN_CNT_EN
      , .underrun_cnt(cnt_s)
`endif
   );

   logic [7:0] pipe_b [LAT];
   logic [7:0] pipe_s [LAT];

   always @(posedge clk) begin
      pipe_b[0] <= rd_b ? ram_val(addr_b) : 8'hEE;
      pipe_s[0] <= rd_s ? ram_val(addr_s) : 8'hEE;
      for (int i = 1; i < LAT; i++) begin
         pipe_b[i] <= pipe_b[i-1];
         pipe_s[i] <= pipe_s[i-1];
      end
   end
   assign q_b = pipe_b[LAT-1];
   assign q_s = pipe_s[LAT-1];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
      end
   endtask

   task automatic wait_rdy(input bit big, input string nm);
      for (int k = 0; k < 60; k++) begin
         if (big ? rdy_b : rdy_s) break;
         @(negedge clk);
      end
      chk(nm, 0, big ? rdy_b : rdy_s, 1);
   endtask

   typedef struct {
      logic        fs;
      logic        req;
      logic        rd;
      logic [15:0] addr;
      logic        rdy;
      logic        pv;
      logic [7:0]  pd;
      logic        un;
   } vec_t;

   vec_t vec[26];

   int          m_state, m_issued, m_cyc;
   int          inf_addr[$];
   int          inf_due[$];
   logic [7:0]  m_fifo[$];
   logic [7:0]  m_pd;
   logic        m_pv, m_un, exp_rd;
   int          m_ucnt;
   logic        p1_rd, p2_rd;
   logic [15:0] p1_a, p2_a;
   bit          found;

   initial begin
      // row k: outputs expected at negedge of cycle k, then inputs for k
      for (int i = 0; i < 26; i++)
         vec[i] = '{fs:0, req:0, rd:0, addr:0, rdy:0, pv:0, pd:0, un:0};
      vec[0].fs = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         vec[i].rd   = 1'b1;
         vec[i].addr = 16'(i - 1);
      end
      for (int i = 5; i <= 8; i++)
         vec[i].addr = 16'd4;
      // FIFO full six edges after the edge that samples frame_start
      for (int i = 7; i <= 25; i++)
         vec[i].rdy = 1'b1;
      for (int i = 8; i <= 23; i++)
         vec[i].req = 1'b1;
      for (int i = 9; i <= 24; i++) begin
         vec[i].rd   = 1'b1;
         vec[i].addr = 16'(i - 5);
         vec[i].pv   = 1'b1;
         vec[i].pd   = 8'(i - 9);
      end
      vec[25].addr = 16'd20;
      vec[25].pd   = 8'h0F;

      rst = 1'b1; fs_b = 0; req_b = 0; fs_s = 0; req_s = 0;
      ram_xor = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_addr", 0, addr_b, 0);
      chk("rst_rd", 0, rd_b, 0);
      chk("rst_pd", 0, pd_b, 0);
      chk("rst_pv", 0, pv_b, 0);
      chk("rst_rdy", 0, rdy_b, 0);
      chk("rst_un", 0, un_b, 0);
      chk("rst_s_rd", 0, rd_s, 0);
      chk("rst_s_pv", 0, pv_s, 0);
      rst = 1'b0;

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         chk("t_rd", i, rd_b, vec[i].rd);
         chk("t_addr", i, addr_b, vec[i].addr);
         chk("t_rdy", i, rdy_b, vec[i].rdy);
         chk("t_pv", i, pv_b, vec[i].pv);
         chk("t_pd", i, pd_b, vec[i].pd);
         chk("t_un", i, un_b, vec[i].un);
         fs_b  = vec[i].fs;
         req_b = vec[i].req;
      end

      // restart while the reads of addresses 40 and 41 are in flight
      req_b = 1'b1; p1_rd = 0; p2_rd = 0; p1_a = 0; p2_a = 0; found = 0;
      for (int k = 0; k < 120 && !found; k++) begin
         @(negedge clk);
         if (p1_rd && p1_a == 16'd41 && p2_rd && p2_a == 16'd40)
            found = 1;
         else begin
            p2_rd = p1_rd; p2_a = p1_a;
            p1_rd = rd_b;  p1_a = addr_b;
         end
      end
      chk("fl_found", 0, found, 1);
      chk("fl_un", 0, un_b, 0);
      fs_b = 1'b1; req_b = 1'b0;
      @(negedge clk);
      fs_b = 1'b0;
      wait_rdy(1, "fl_rdy");
      req_b = 1'b1;
      @(negedge clk);
      chk("fl_pv0", 0, pv_b, 1);
      chk("fl_pd0", 0, pd_b, 8'h00);
      @(negedge clk);
      req_b = 1'b0;
      chk("fl_pv1", 0, pv_b, 1);
      chk("fl_pd1", 0, pd_b, 8'h01);

      // pop on the first PREFILL cycle
      fs_b = 1'b1;
      @(negedge clk);
      fs_b = 1'b0; req_b = 1'b1;
      @(negedge clk);
      req_b = 1'b0;
      chk("pf_pv", 0, pv_b, 0);
      chk("pf_un", 0, un_b, 1);
      chk("pf_pd", 0, pd_b, 8'h00);
      chk("pf_rdy", 0, rdy_b, 0);
`ifdef FB_FETCH_UNDERRUN_CNT_EN
      chk("pf_cnt", 0, cnt_b, 1);
`endif

      // reset mid-stream with pix_req held high
      wait_rdy(1, "mr_rdy");
      req_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mr_pv", i, pv_b, 1);
         chk("mr_pd", i, pd_b, 8'(i));
         chk("mr_un", i, un_b, 1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mr_addr", 0, addr_b, 0);
      chk("mr_rd", 0, rd_b, 0);
      chk("mr_pd", 9, pd_b, 0);
      chk("mr_pv", 9, pv_b, 0);
      chk("mr_rdy", 0, rdy_b, 0);
      chk("mr_un", 9, un_b, 0);
`ifdef FB_FETCH_UNDERRUN_CNT_EN
      chk("mr_cnt", 0, cnt_b, 0);
`endif
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("idle_rd", i, rd_b, 0);
         chk("idle_pv", i, pv_b, 0);
         chk("idle_un", i, un_b, 0);
      end
      req_b = 1'b0;

      // whole 4x2 frame, then one pop past the end
      fs_s = 1'b1;
      @(negedge clk);
      fs_s = 1'b0;
      wait_rdy(0, "sf_rdy");
      req_s = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i < 8) begin
            chk("sf_pv", i, pv_s, 1);
            chk("sf_pd", i, pd_s, 8'(i));
            chk("sf_un", i, un_s, 0);
         end else begin
            req_s = 1'b0;
            chk("sf_end_pv", 0, pv_s, 0);
            chk("sf_end_pd", 0, pd_s, 8'h00);
            chk("sf_end_un", 0, un_s, 1);
            chk("sf_end_rdy", 0, rdy_s, 0);
            chk("sf_end_rd", 0, rd_s, 0);
         end
      end

      // randomized traffic on the 4x2 instance against the model
      ram_xor = 8'h5A;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_state = M_IDLE; m_issued = 0; m_cyc = 0;
      inf_addr.delete(); inf_due.delete(); m_fifo.delete();
      m_pd = 0; m_pv = 0; m_un = 0; m_ucnt = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         exp_rd = (m_state == M_PRE || m_state == M_STR) &&
                  m_issued < S_TOT &&
                  (m_fifo.size() + inf_addr.size()) < S_DEPTH;
         chk("m_rd", c, rd_s, exp_rd);
         if (exp_rd)
            chk("m_addr", c, addr_s, m_issued);
         chk("m_rdy", c, rdy_s, m_state == M_STR);
         chk("m_pv", c, pv_s, m_pv);
         chk("m_pd", c, pd_s, m_pd);
         chk("m_un", c, un_s, m_un);
`ifdef FB_FETCH_UNDERRUN_CNT_EN
         chk("m_cnt", c, cnt_s, m_ucnt);
`endif
         rst   = ($urandom_range(0, 999) < 4);
         fs_s  = !rst && ($urandom_range(0, 99) < 3);
         req_s = ($urandom_range(0, 99) < 70);
         if (rst || fs_s) begin
            m_state = rst ? M_IDLE : M_PRE;
            m_issued = 0;
            inf_addr.delete(); inf_due.delete(); m_fifo.delete();
            m_pv = 0; m_un = 0; m_ucnt = 0;
            if (rst) m_pd = 0;
         end else begin
            m_pv = 0;
            if (m_state != M_IDLE && req_s) begin
               if (m_fifo.size() > 0) begin
                  m_pd = m_fifo.pop_front();
                  m_pv = 1;
               end else begin
                  m_pd = 0;
                  m_un = 1;
                  if (m_ucnt < 65535) m_ucnt++;
               end
            end
            if (inf_due.size() > 0 && inf_due[0] == m_cyc) begin
               m_fifo.push_back(ram_val(16'(inf_addr[0])));
               void'(inf_addr.pop_front());
               void'(inf_due.pop_front());
            end
            if (exp_rd) begin
               inf_addr.push_back(m_issued);
               inf_due.push_back(m_cyc + LAT);
               m_issued++;
            end
            if (m_state == M_PRE &&
                (m_fifo.size() == S_DEPTH ||
                 (m_issued == S_TOT && inf_addr.size() == 0)))
               m_state = M_STR;
            else if (m_state == M_STR && m_issued == S_TOT &&
                     inf_addr.size() == 0 && m_fifo.size() == 0)
               m_state = M_DONE;
         end
         m_cyc++;
      end
      rst = 1'b0; fs_s = 1'b0; req_s = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fb_pixel_fetch.md
FB_PIXEL_FETCH -- requirements
Module: fb_pixel_fetch

Interface
REQ-001 Parameter IMG_W, default 256, active pixels per line read from the framebuffer.
REQ-002 Parameter IMG_H, default 256, lines per frame.
REQ-003 Parameter ADDR_W, default 16, framebuffer address width.
REQ-004 Parameter RAM_LAT, default 2, cycles from ram_addr valid to ram_q valid.
REQ-005 Parameter FIFO_DEPTH, default 4, prefetch FIFO entries (power of two, >= RAM_LAT+1).
REQ-006 clk  in  1  single clock, shared with the framebuffer RAM port; one clock, reset synchronous active-high.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 frame_start  in  1  one-cycle pulse; restart fetch at address 0.
REQ-009 pix_req  in  1  VGA consumer pops one pixel this cycle.
REQ-010 ram_addr  out  ADDR_W  framebuffer read address.
REQ-011 ram_rd  out  1  read issued this cycle.
REQ-012 ram_q  in  8  read data, valid RAM_LAT cycles after ram_rd.
REQ-013 pix_data  out  8  pixel delivered to the VGA stage.
REQ-014 pix_valid  out  1  pix_data holds a real fetched pixel.
REQ-015 fetch_ready  out  1  FIFO primed; consumer may start popping.
REQ-016 underrun  out  1  sticky: a pop hit an empty FIFO.

Function
REQ-017 States: IDLE, PREFILL, STREAM, DONE; reset enters IDLE.
REQ-018 IDLE -> PREFILL on frame_start; frame_start in any state SHALL force PREFILL next cycle, clear address counter, FIFO and underrun.
REQ-019 Issue rule: ram_rd=1 iff state is PREFILL/STREAM, issued count < IMG_W*IMG_H, and fifo_count + inflight < FIFO_DEPTH.
REQ-020 ram_addr SHALL equal the issued-read count and increment by 1 per issued read, linear raster order.
REQ-021 Data returning RAM_LAT cycles after ram_rd SHALL be pushed into the FIFO in issue order; a valid-flag shift register of length RAM_LAT tracks in-flight reads.
REQ-022 On frame_start, all in-flight reads SHALL be discarded (valid flags cleared), never pushed.
REQ-023 PREFILL -> STREAM when fifo_count == FIFO_DEPTH or all IMG_W*IMG_H reads have returned; fetch_ready=1 only in STREAM.
REQ-024 pix_req with FIFO non-empty: pop head; pix_data/pix_valid update on the next edge (latency 1), pix_valid=1.
REQ-025 pix_req with FIFO empty: pix_data=8'h00, pix_valid=0 next cycle, underrun set until reset or frame_start.
REQ-026 No pix_req: pix_valid=0 next cycle, pix_data holds last value.
REQ-027 Simultaneous push and pop in one cycle SHALL leave fifo_count unchanged; FIFO never overflows (guaranteed by REQ-019).
REQ-028 STREAM -> DONE when all reads issued, none in flight, FIFO empty; DONE holds ram_rd=0 until frame_start.
REQ-029 pix_req in IDLE/DONE SHALL be treated as REQ-025 only in DONE; ignored in IDLE.

Reset
REQ-030 On reset: state IDLE, ram_addr=0, ram_rd=0, pix_data=0, pix_valid=0, fetch_ready=0, underrun=0, FIFO and in-flight flags cleared.
REQ-031 reset has priority over frame_start and pix_req in the same cycle.

Configuration
REQ-032 Macro FB_FETCH_UNDERRUN_CNT_EN defined: adds output underrun_cnt [15:0], increments per underrun pop, saturates at 16'hFFFF, cleared by reset and frame_start.
REQ-033 Macro undefined: port underrun_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-034 Reset, frame_start, no pix_req, RAM holds addr[7:0] -> exactly 4 reads (addr 0..3), fetch_ready=1 at cycle 6 after frame_start, ram_rd then stays 0.
REQ-035 STREAM, pix_req held high 16 cycles -> pix_data 00,01,..,0F consecutive with pix_valid=1, underrun=0.
REQ-036 IMG_W=4, IMG_H=2, continuous pix_req -> 8 pixels 00..07, then pix_data=00, pix_valid=0, underrun=1, state DONE.
REQ-037 frame_start issued while 2 reads in flight at addr 40,41 -> neither pushed; next popped pixel is from addr 0.
REQ-038 pix_req asserted during PREFILL cycle 1 (FIFO empty) -> underrun=1, pix_valid=0; with FB_FETCH_UNDERRUN_CNT_EN, underrun_cnt=1.
REQ-039 reset asserted mid-STREAM with pix_req=1 -> all outputs at REQ-030 values next cycle, no further ram_rd until frame_start.
